// File: rtl/sha3_pkg.sv
// ---------------------------------------------------------------------------
// sha3_pkg
// Shared constants and types for the SHA3 input path.
//   RATE_BYTES  : SHA3-512 rate in bytes (576 bits)
//   PAD_FIRST   : domain/pad byte placed right after the last message byte
//   PAD_LAST    : pad byte OR-ed into the final byte of the rate block
//   PAD_BLOCK   : a complete padding-only rate block (0x06 ... 0x80)
//   state_t     : packer FSM states
// ---------------------------------------------------------------------------
package sha3_pkg;

    localparam int RATE_BYTES = 72;

    localparam logic [7:0] PAD_FIRST = 8'h06;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    localparam logic [8*RATE_BYTES-1:0] PAD_BLOCK =
        {PAD_LAST, {(8*RATE_BYTES-16){1'b0}}, PAD_FIRST};

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_OUT    = 2'd1,
        ST_PADBLK = 2'd2
    } state_t;

endpackage

// File: rtl/sha3_lane_byteswap.sv
// ---------------------------------------------------------------------------
// sha3_lane_byteswap
// Converts a big-endian message word (first byte in [63:56]) into a
// little-endian lane (first byte in [7:0]) and zeroes every byte at or
// beyond the valid byte count.
//   word   : input message word
//   nbytes : valid bytes counted from the MSB, 0..8
//   lane   : byte-reversed, masked lane
// ---------------------------------------------------------------------------
module sha3_lane_byteswap (
    input  logic [63:0] word,
    input  logic [3:0]  nbytes,
    output logic [63:0] lane
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_byte
            assign lane[8*gi +: 8] = (4'(gi) < nbytes) ? word[63-8*gi -: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/sha3_input_packer.sv
// ---------------------------------------------------------------------------
// sha3_input_packer
// Packs a stream of 64-bit message words into 576-bit SHA3-512 rate blocks.
// Optional SHA3 padding is compiled in with the macro SHA3_INPUT_PAD_EN.
//
// Ports
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   in_valid     : message word valid
//   in_ready     : packer accepts a word this cycle (FILL state only)
//   in_data      : message word, first byte in [63:56]
//   in_last      : final message word
//   in_bytes     : valid bytes in the final word (0..8, clamped to 8)
//   blk_valid    : rate block valid (OUT / PADBLK states)
//   blk_ready    : consumer accepts the block
//   blk_data     : rate block, message byte k at [8k+7:8k]
//   blk_nbytes   : message bytes carried by the block (0..72)
//   blk_last     : final block of the message
// ---------------------------------------------------------------------------
module sha3_input_packer
    import sha3_pkg::*;
#(
    parameter int WORD_W     = 64,
    parameter int RATE_LANES = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_W-1:0]       in_data,
    input  logic                    in_last,
    input  logic [3:0]              in_bytes,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [8*RATE_BYTES-1:0] blk_data,
    output logic [6:0]              blk_nbytes,
    output logic                    blk_last
);

    localparam logic [3:0] LANE_LAST = 4'(RATE_LANES - 1);

    state_t                  state_reg,    state_next;
    logic [3:0]              lane_reg,     lane_next;
    logic [8*RATE_BYTES-1:0] buf_reg,      buf_next;
    logic [6:0]              nbytes_reg,   nbytes_next;
    logic                    last_reg,     last_next;
    logic                    exact_reg,    exact_next;
    logic                    in_ready_reg, in_ready_next;

    logic [3:0]              eff_bytes;
    logic [6:0]              nb_word;
    logic                    block_done;
    logic [63:0]             swapped;
    logic [8*RATE_BYTES-1:0] buf_lane;
    logic [8*RATE_BYTES-1:0] buf_fill;
    logic                    exact_pad;

    // Non-final words are always full; an oversized count on the final word
    // is clamped to a full word.
    assign eff_bytes  = !in_last ? 4'd8 : ((in_bytes > 4'd8) ? 4'd8 : in_bytes);
    assign nb_word    = {lane_reg, 3'b000} + {3'b000, eff_bytes};
    assign block_done = in_last || (lane_reg == LANE_LAST);

    sha3_lane_byteswap u_swap (
        .word   (in_data),
        .nbytes (eff_bytes),
        .lane   (swapped)
    );

    // Drop the swapped word into the lane selected by the lane counter.
    genvar gi;
    generate
        for (gi = 0; gi < RATE_LANES; gi++) begin : g_lane
            assign buf_lane[64*gi +: 64] = (lane_reg == 4'(gi)) ? swapped : buf_reg[64*gi +: 64];
        end
    endgenerate

`ifdef SHA3_INPUT_PAD_EN
    logic                    exact_fill;
    logic [8*RATE_BYTES-1:0] pad_vec;

    // A final word landing exactly on the last byte of the rate leaves no
    // room for padding; the pad goes into a separate all-padding block.
    assign exact_fill = in_last && (lane_reg == LANE_LAST) && (eff_bytes == 4'd8);

    // 0x06 right after the last message byte, 0x80 in the top byte; the two
    // merge into 0x86 when the message ends on byte 70.
    generate
        for (gi = 0; gi < RATE_BYTES; gi++) begin : g_pad
            assign pad_vec[8*gi +: 8] = ((7'(gi) == nb_word) ? PAD_FIRST : 8'h00) |
                                        ((gi == RATE_BYTES - 1) ? PAD_LAST : 8'h00);
        end
    endgenerate

    assign buf_fill  = (in_last && !exact_fill) ? (buf_lane | pad_vec) : buf_lane;
    assign exact_pad = exact_fill;
`else
    assign buf_fill  = buf_lane;
    assign exact_pad = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        lane_next   = lane_reg;
        buf_next    = buf_reg;
        nbytes_next = nbytes_reg;
        last_next   = last_reg;
        exact_next  = exact_reg;

        case (state_reg)
            ST_FILL: begin
                if (in_valid && in_ready_reg) begin
                    buf_next    = buf_fill;
                    nbytes_next = nb_word;
                    if (block_done) begin
                        state_next = ST_OUT;
                        last_next  = in_last && !exact_pad;
                        exact_next = exact_pad;
                    end else begin
                        lane_next = lane_reg + 4'd1;
                    end
                end
            end
            ST_OUT: begin
                if (blk_ready) begin
                    lane_next = 4'd0;
                    if (exact_reg) begin
                        state_next  = ST_PADBLK;
                        buf_next    = PAD_BLOCK;
                        nbytes_next = 7'd0;
                        last_next   = 1'b1;
                        exact_next  = 1'b0;
                    end else begin
                        state_next  = ST_FILL;
                        buf_next    = '0;
                        nbytes_next = 7'd0;
                        last_next   = 1'b0;
                    end
                end
            end
            ST_PADBLK: begin
                if (blk_ready) begin
                    state_next  = ST_FILL;
                    lane_next   = 4'd0;
                    buf_next    = '0;
                    nbytes_next = 7'd0;
                    last_next   = 1'b0;
                    exact_next  = 1'b0;
                end
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase

        // Registered so in_ready stays low during reset and rises on the
        // first edge after release.
        in_ready_next = (state_next == ST_FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_FILL;
            lane_reg     <= 4'd0;
            buf_reg      <= '0;
            nbytes_reg   <= 7'd0;
            last_reg     <= 1'b0;
            exact_reg    <= 1'b0;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            lane_reg     <= lane_next;
            buf_reg      <= buf_next;
            nbytes_reg   <= nbytes_next;
            last_reg     <= last_next;
            exact_reg    <= exact_next;
            in_ready_reg <= in_ready_next;
        end
    end

    assign in_ready   = in_ready_reg;
    assign blk_valid  = (state_reg == ST_OUT) || (state_reg == ST_PADBLK);
    assign blk_data   = buf_reg;
    assign blk_nbytes = nbytes_reg;
    assign blk_last   = last_reg;

endmodule

// File: doc/sha3_input_packer.md
SHA3_INPUT_PACKER -- requirements
Module: sha3_input_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 64: input word width in bits, fixed at 64.
REQ-002 SHALL have parameter RATE_LANES, default 9: 64-bit lanes per rate block (576-bit SHA3-512 rate, RATE_BYTES = 72).
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: input word valid.
REQ-006 SHALL have port in_ready, output, 1: packer accepts a word this cycle.
REQ-007 SHALL have port in_data, input, 64: message word; in_data[63:56] is the first message byte.
REQ-008 SHALL have port in_last, input, 1: word is the final message word.
REQ-009 SHALL have port in_bytes, input, 4: valid bytes in the last word (0..8), from the MSB downward.
REQ-010 SHALL have port blk_valid, output, 1: rate block valid.
REQ-011 SHALL have port blk_ready, input, 1: consumer accepts the block.
REQ-012 SHALL have port blk_data, output, 576: block; message byte k of the block at blk_data[8k+7:8k].
REQ-013 SHALL have port blk_nbytes, output, 7: message bytes in the block (0..72).
REQ-014 SHALL have port blk_last, output, 1: final block of the message.

Function
REQ-015 SHALL implement states FILL, OUT and PADBLK.
- Handshake completes when valid and ready are both high on a clk edge.
REQ-016 SHALL drive in_ready high only in FILL; blk_valid high only in OUT or PADBLK.
REQ-017 SHALL byte-reverse each accepted word into lane L (lane counter 0..8), so in_data[63:56] becomes byte 8L.
- Bytes at or beyond in_bytes SHALL be zeroed.
REQ-018 SHALL treat in_bytes as 8 when in_last=0.
- in_bytes > 8 with in_last=1 SHALL be clamped to 8.
REQ-019 SHALL go from FILL to OUT on the handshake of lane 8 or of any word with in_last=1.
- blk_valid SHALL rise the following cycle (latency 1).
REQ-020 SHALL hold blk_data, blk_nbytes and blk_last stable while blk_valid=1 and blk_ready=0.
REQ-021 SHALL, on the OUT handshake, clear the buffer, zero the lane counter and return to FILL.
- Exception: when the exact-fill condition of REQ-024 holds, it SHALL go to PADBLK instead.
REQ-022 SHALL, on the PADBLK handshake, return to FILL with an empty buffer.
REQ-023 SHALL ignore in_data, in_last and in_bytes when in_valid=0 or in_ready=0.
REQ-024 SHALL define exact fill as: last word accepted at lane 8 with in_bytes=8 (72 message bytes).

Reset
REQ-025 SHALL, on rst_n low and regardless of state, asynchronously force:
- state FILL, lane counter 0, buffer 0;
- in_ready=0 while rst_n is low, then 1 from the first edge after release;
- blk_valid=0, blk_data=0, blk_nbytes=0, blk_last=0.
REQ-026 SHALL discard a partially filled block on reset mid-operation.

Configuration
REQ-027 SHALL compile SHA3 padding in when SHA3_INPUT_PAD_EN is defined.
- The final block SHALL have byte nbytes OR 0x06 and byte 71 OR 0x80 (0x86 when nbytes=71).
- On exact fill it SHALL emit an extra PADBLK block: nbytes=0, bytes 0x06 ... 0x80, blk_last=1; the full block then carries blk_last=0.
REQ-028 SHALL, without SHA3_INPUT_PAD_EN, emit no padding and no PADBLK.
- The final block SHALL be zero-filled beyond nbytes, with blk_last=1.

Structure
REQ-029 SHALL take RATE_BYTES, the pad constants 0x06/0x80 and the state enum from shared package sha3_pkg.
REQ-030 SHALL instantiate one sub-module, sha3_lane_byteswap (64-bit byte reversal with byte masking by count).

Verification
REQ-031 Empty message: in_bytes=0, in_last=1 -> one block, byte0=0x06, byte71=0x80, rest 0, nbytes=0, blk_last=1.
REQ-032 "abc": in_data=0x6162630000000000, in_bytes=3, in_last=1 -> blk_data[31:0]=0x06636261, byte71=0x80, nbytes=3.
REQ-033 71 bytes: 8 full words, then in_bytes=7 last -> byte71=0x86, nbytes=71, single block.
REQ-034 72 bytes: 9 full words, last on lane 8 -> block nbytes=72, blk_last=0; then pad block 0x06 ... 0x80 with blk_last=1.
- Without the macro: single block, blk_last=1.
REQ-035 Backpressure: blk_ready low for 5 cycles -> blk_valid and blk_data stable, in_ready=0 throughout.
REQ-036 rst_n pulsed after 4 accepted words -> outputs zero; the next 9 words form a fresh block starting at lane 0.
